// File: rtl/dmem_bus_master.sv
// Data-memory bus initiator: one load/store per transaction, checked,
// driven on DAD/DDT/MREQ and completed on ACKD_n or timeout.
module dmem_bus_master #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [BIT_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n,
  inout  wire  [BIT_WIDTH-1:0] DDT
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP,
    ERR
  } state_t;

  state_t               state;
  logic                 we_q;
  logic [2:0]           f3_q;
  logic [CNT_W-1:0]     cnt;
  logic                 ddt_oe;
  logic [BIT_WIDTH-1:0] ddt_out;

  logic                 illegal;
  logic                 misal;
  logic [1:0]           size_n;
  logic [BIT_WIDTH-1:0] wdata_n;
  logic [BIT_WIDTH-1:0] ld_data;
  logic                 to_hit;

  assign DDT = ddt_oe ? ddt_out : {BIT_WIDTH{1'bz}};

  always_comb begin
    illegal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase
  end

  assign misal =
    (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
    (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    size_n  = 2'b00;
    wdata_n = req_wdata;
    unique case (req_funct3[1:0])
      2'b00: begin
        size_n  = 2'b10;
        wdata_n = {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
      end
      2'b01: begin
        size_n  = 2'b01;
        wdata_n = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
      end
      default: begin
        size_n  = 2'b00;
        wdata_n = req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_data = DDT;
    unique case (f3_q)
      3'b000: ld_data = {{(BIT_WIDTH-8){DDT[7]}}, DDT[7:0]};
      3'b100: ld_data = {{(BIT_WIDTH-8){1'b0}}, DDT[7:0]};
      3'b001: ld_data = {{(BIT_WIDTH-16){DDT[15]}}, DDT[15:0]};
      3'b101: ld_data = {{(BIT_WIDTH-16){1'b0}}, DDT[15:0]};
      default: ld_data = DDT;
    endcase
    if (we_q) ld_data = '0;
  end

  // A zero TIMEOUT leaves the master waiting for an ack indefinitely
  assign to_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      cnt       <= '0;
      ddt_oe    <= 1'b0;
      ddt_out   <= '0;
      DAD       <= '0;
      MREQ      <= 1'b0;
      WRITE     <= 1'b0;
      SIZE      <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            cnt       <= '0;
            if (illegal || misal) begin
              state     <= ERR;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state   <= BUS;
              MREQ    <= 1'b1;
              DAD     <= req_addr;
              WRITE   <= req_we;
              SIZE    <= size_n;
              ddt_oe  <= req_we;
              ddt_out <= wdata_n;
            end
          end
        end
        BUS: begin
          if (!ACKD_n) begin
            state     <= RESP;
            cnt       <= '0;
            MREQ      <= 1'b0;
            WRITE     <= 1'b0;
            ddt_oe    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= ld_data;
          end else if (to_hit) begin
            state     <= ERR;
            cnt       <= '0;
            MREQ      <= 1'b0;
            WRITE     <= 1'b0;
            ddt_oe    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP, ERR: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_bus_master.md
Name: dmem_bus_master

Overview:
- Processor-side initiator for the external data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Accepts one load/store per transaction from the MEM stage.
- Checks alignment and funct3, then drives the bus and waits for a variable-latency ACKD_n.
- Returns sign/zero-extended load data or an error, and stalls the pipeline while busy.

Parameters:
- BIT_WIDTH, 32, data/address width.
- TIMEOUT, 1024, max cycles in BUS before abort with error; 0 disables the timeout.
- CNT_W, 11, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal funct3, or timeout.
- busy  out  1  stall to pipeline.
- DAD  out  32  bus address.
- MREQ  out  1  bus request.
- WRITE  out  1  bus write.
- SIZE  out  2  00 word, 01 half, 10 byte.
- ACKD_n  in  1  responder acknowledge, active-low.
- DDT  inout  32  bidirectional data bus, right-aligned.

Behaviour:
Reset (rst=0 at a rising edge):
- State IDLE.
- MREQ=0, WRITE=0, SIZE=00, DAD=0.
- DDT released (high-Z).
- rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, timeout counter 0.
- Reset mid-transaction aborts the transaction with no response; MREQ is low the cycle after the reset edge.

States:
- IDLE: req_ready=1, busy=0. When req_valid=1 at an edge:
  - Latch we, funct3, addr, wdata.
  - Illegal funct3 → ERR. Illegal means: 011, 110, 111, or any of 100/101 with we=1.
  - Misaligned → ERR. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise → BUS.
- BUS: MREQ=1, busy=1, req_ready=0.
  - DAD = latched addr. WRITE = we. SIZE from funct3[1:0]: 00→10, 01→01, 10→00.
  - All bus outputs stay stable for the whole BUS state.
  - Store: DDT driven for the whole BUS state with {24'b0,wdata[7:0]}, {16'b0,wdata[15:0]} or wdata, per size.
  - Load: DDT high-Z.
  - ACKD_n sampled at each rising edge while in BUS.
  - ACKD_n=0 → capture DDT (loads), counter cleared, go RESP.
  - ACKD_n=1 → counter += 1; when counter reaches TIMEOUT-1 with no ack → ERR.
  - Minimum bus occupancy is 1 cycle; a responder may assert ACKD_n in the first BUS cycle.
- RESP: one cycle, MREQ=0, DDT released. Then → IDLE.
  - rsp_valid=1, rsp_err=0.
  - LB: rsp_rdata = sign-extend DDT[7:0]. LBU: zero-extend DDT[7:0].
  - LH: sign-extend DDT[15:0]. LHU: zero-extend DDT[15:0].
  - LW: DDT[31:0]. Stores: rsp_rdata=0.
- ERR: one cycle, rsp_valid=1, rsp_err=1, rsp_rdata=0, no bus activity. Then → IDLE.

Pipeline and bus rules:
- busy=1 in BUS, RESP and ERR. A new request is not accepted until IDLE.
- Minimum issue-to-response latency is 2 edges (IDLE→BUS, BUS→RESP), plus 1 edge per extra wait cycle.
- ACKD_n while not in BUS is ignored.
- req_valid while not in IDLE is ignored; the core holds it.
- Bus byte-lane placement within memory is the responder's job; the master always uses right-aligned DDT with SIZE.
- The address goes out unmodified (including addr[1:0]) for byte and half accesses.
- STDOUT and EXIT addresses are ordinary stores to this block.

Test Plan:
- LW 0x0800_0010, responder acks in first BUS cycle returning 0x1234_5678 → MREQ=1 for exactly 1 cycle, SIZE=00, WRITE=0, DDT high-Z; rsp_valid 2 edges after issue with rsp_rdata=0x1234_5678.
- LB and LBU at 0x0800_0003, DDT=0x0000_0080, ack after 3 wait cycles → MREQ held 4 cycles; LB returns 0xFFFF_FF80, LBU returns 0x0000_0080; SIZE=10 and DAD stable throughout.
- SH 0x0800_0002 with wdata=0xDEAD_BEEF → DDT=0x0000_BEEF, WRITE=1, SIZE=01 while MREQ=1; DDT high-Z after ack; rsp_valid=1, rsp_rdata=0.
- LW 0x0800_0002, LH 0x0800_0001, and funct3=011 → no MREQ pulse; rsp_err=1 one edge after issue for each.
- TIMEOUT=8, ACKD_n held 1 → MREQ high 8 cycles, then rsp_err=1, MREQ=0; next request accepted normally.
- rst=0 in the 2nd BUS cycle of a store → MREQ=0, DDT high-Z, no rsp_valid; first request after reset completes normally.
